// File: rtl/cic_gain_bank_pkg.sv
// Shared register map and control-bit layout for the CIC gain/shift bank.
package cic_gain_bank_pkg;

  localparam logic [4:0] SHADOW_BASE = 5'h00;
  localparam logic [4:0] ACTIVE_BASE = 5'h08;
  localparam logic [4:0] CTRL_ADDR   = 5'h10;
  localparam logic [4:0] STATUS_ADDR = 5'h11;
  localparam logic [4:0] CNT_ADDR    = 5'h12;

  localparam int COMMIT_BIT   = 0;
  localparam int IMM_BIT      = 1;
  localparam int ABORT_BIT    = 2;
  localparam int MAX_NCH      = 8;
  localparam int COMMIT_CNT_W = 16;

endpackage

// File: rtl/cic_gain_bank_chan_reg.sv
// One channel: CPU-facing shadow register and the DSP-facing active copy.
module gain_chan_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             apply,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);

  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] active_reg;

  // A shadow write in the apply cycle lands in shadow only; active takes the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= RESET_VAL;
      active_reg <= RESET_VAL;
    end else begin
      if (wr_en) shadow_reg <= wdata;
      if (apply) active_reg <= shadow_reg;
    end
  end

  assign shadow = shadow_reg;
  assign active = active_reg;

endmodule

// File: rtl/cic_gain_bank.sv
// Avalon-MM bank of NCH gain/shift controls with atomic, tick-aligned or immediate commit.
module cic_gain_bank
  import cic_gain_bank_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic                 sample_tick,
  output logic [NCH*WIDTH-1:0] out_port,
  output logic                 update
);

  logic                    wr;
  logic                    ctrl_wr;
  logic                    apply;
  logic                    pending_reg;
  logic                    pending_next;
  logic                    imm_reg;
  logic                    update_reg;
  logic [COMMIT_CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0]        chan_shadow [NCH];
  logic [WIDTH-1:0]        chan_active [NCH];

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr && (address == CTRL_ADDR);
  // Registered state only, so the COMMIT write cycle can never apply itself.
  assign apply   = pending_reg & (imm_reg | sample_tick);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      gain_chan_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr && (address == SHADOW_BASE + 5'(gi))),
        .wdata  (writedata[WIDTH-1:0]),
        .apply  (apply),
        .shadow (chan_shadow[gi]),
        .active (chan_active[gi])
      );
      assign out_port[gi*WIDTH +: WIDTH] = chan_active[gi];
    end
  endgenerate

  // A CTRL write overrides the apply-clear: COMMIT re-arms, ABORT beats COMMIT.
  always_comb begin
    pending_next = pending_reg;
    if (apply) pending_next = 1'b0;
    if (ctrl_wr) begin
      if (writedata[ABORT_BIT])       pending_next = 1'b0;
      else if (writedata[COMMIT_BIT]) pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      imm_reg     <= 1'b0;
      cnt_reg     <= '0;
      update_reg  <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      update_reg  <= apply;
      if (ctrl_wr) imm_reg <= writedata[IMM_BIT];
      if (apply)   cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign update = update_reg;

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (address == SHADOW_BASE + 5'(k)) readdata[WIDTH-1:0] = chan_shadow[k];
      if (address == ACTIVE_BASE + 5'(k)) readdata[WIDTH-1:0] = chan_active[k];
    end
    case (address)
      CTRL_ADDR:   readdata[IMM_BIT] = imm_reg;
      STATUS_ADDR: readdata[0] = pending_reg;
      CNT_ADDR:    readdata[COMMIT_CNT_W-1:0] = cnt_reg;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_cic_gain_bank.sv
// Directed bench for cic_gain_bank (NCH=4, WIDTH=4, RESET_VAL=0).
module tb_cic_gain_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        sample_tick = 1'b0;
  logic [15:0] out_port;
  logic        update;

  int n_tests = 0;
  int n_fail  = 0;

  cic_gain_bank #(.NCH(4), .WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .sample_tick (sample_tick),
    .out_port    (out_port),
    .update      (update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic tick;
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  initial begin
    // Reset
    step(2);
    reset = 1'b0;
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    read_check("rst_shadow0", 5'h00, 32'h0);
    read_check("rst_active0", 5'h08, 32'h0);
    read_check("rst_ctrl", 5'h10, 32'h0);
    read_check("rst_status", 5'h11, 32'h0);
    read_check("rst_cnt", 5'h12, 32'h0);

    // Tick-aligned commit
    bus_write(5'h00, 32'h5);
    bus_write(5'h01, 32'hA);
    bus_write(5'h10, 32'h1);
    read_check("tick_status_pend", 5'h11, 32'h1);
    check("tick_out_hold0", 32'(out_port), 32'h0);
    step(3);
    check("tick_out_hold1", 32'(out_port), 32'h0);
    check("tick_no_update", 32'(update), 32'h0);
    read_check("tick_status_pend2", 5'h11, 32'h1);
    tick();
    check("tick_out_applied", 32'(out_port[7:0]), 32'hA5);
    check("tick_update_hi", 32'(update), 32'h1);
    step(1);
    check("tick_update_lo", 32'(update), 32'h0);
    read_check("tick_cnt", 5'h12, 32'h1);
    read_check("tick_status_clr", 5'h11, 32'h0);
    read_check("tick_active0", 5'h08, 32'h5);
    read_check("tick_active1", 5'h09, 32'hA);

    // Immediate mode
    bus_write(5'h10, 32'h2);
    read_check("imm_ctrl", 5'h10, 32'h2);
    bus_write(5'h02, 32'h7);
    bus_write(5'h10, 32'h3);
    check("imm_out_not_yet", 32'(out_port[11:8]), 32'h0);
    check("imm_update_not_yet", 32'(update), 32'h0);
    step(1);
    check("imm_out_applied", 32'(out_port[11:8]), 32'h7);
    check("imm_out_full", 32'(out_port), 32'h07A5);
    check("imm_update_hi", 32'(update), 32'h1);
    read_check("imm_status", 5'h11, 32'h0);
    read_check("imm_cnt", 5'h12, 32'h2);

    // Shadow write colliding with the apply cycle
    bus_write(5'h10, 32'h3);
    bus_write(5'h00, 32'h9);
    check("coll_update", 32'(update), 32'h1);
    read_check("coll_active0_old", 5'h08, 32'h5);
    read_check("coll_shadow0_new", 5'h00, 32'h9);
    read_check("coll_cnt", 5'h12, 32'h3);
    check("coll_out", 32'(out_port), 32'h07A5);

    // Abort before the tick
    bus_write(5'h10, 32'h0);
    bus_write(5'h10, 32'h1);
    read_check("abort_pend", 5'h11, 32'h1);
    bus_write(5'h10, 32'h4);
    read_check("abort_clr", 5'h11, 32'h0);
    tick();
    check("abort_no_update", 32'(update), 32'h0);
    read_check("abort_cnt", 5'h12, 32'h3);
    check("abort_out", 32'(out_port), 32'h07A5);
    bus_write(5'h10, 32'h5);
    read_check("commit_abort_same", 5'h11, 32'h0);

    // Reset while pending
    bus_write(5'h10, 32'h1);
    read_check("rstp_pend", 5'h11, 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    read_check("rstp_status", 5'h11, 32'h0);
    check("rstp_out", 32'(out_port), 32'h0);
    read_check("rstp_cnt", 5'h12, 32'h0);
    read_check("rstp_shadow0", 5'h00, 32'h0);

    // Bounds
    bus_write(5'h06, 32'hF);
    read_check("oob_shadow6", 5'h06, 32'h0);
    read_check("oob_active6", 5'h0E, 32'h0);
    bus_write(5'h08, 32'hF);
    read_check("ro_active0", 5'h08, 32'h0);
    read_check("unmapped_13", 5'h13, 32'h0);
    bus_write(5'h03, 32'hFFFF_FFFF);
    read_check("upper_bits_zero", 5'h03, 32'hF);

    // Counter wrap: back-to-back IMM commits apply once per cycle
    address = 5'h10; writedata = 32'h3; chipselect = 1'b1; write_n = 1'b0;
    step(65535);
    chipselect = 1'b0; write_n = 1'b1;
    step(2);
    read_check("wrap_cnt_ffff", 5'h12, 32'hFFFF);
    read_check("wrap_status_idle", 5'h11, 32'h0);
    bus_write(5'h10, 32'h3);
    step(1);
    read_check("wrap_cnt_zero", 5'h12, 32'h0);
    check("wrap_out", 32'(out_port), 32'hF000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
